// File: rtl/pong_pkg.sv
// Shared types and widths for the Pong playfield control logic.
package pong_pkg;

  localparam int unsigned SCORE_W = 4;
  localparam int unsigned SPEED_W = 2;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SERVE = 3'd1,
    PLAY  = 3'd2,
    POINT = 3'd3,
    OVER  = 3'd4
  } game_state_t;

  // Increment that holds once the limit is reached.
  function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] v,
                                                 input logic [SCORE_W-1:0] lim);
    return (v >= lim) ? v : v + SCORE_W'(1);
  endfunction

endpackage

// File: rtl/frame_tick_gen.sv
// Free-running frame tick: one-cycle pulse every TICK_DIV clocks. tick_next_o is the
// value frame_tick takes on the next edge, for callers that register tick-aligned outputs.
module frame_tick_gen #(
  parameter int unsigned TICK_DIV = 500_000
) (
  input  logic clk_i,
  input  logic rst_ni,
  output logic tick_next_o,
  output logic tick_o
);

  localparam int unsigned CntW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(TICK_DIV - 1);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            tick_q;

  always_comb begin
    tick_next_o = (cnt_q == CntLast);
    cnt_d       = tick_next_o ? '0 : cnt_q + CntW'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_next_o;
    end
  end

  assign tick_o = tick_q;

endmodule

// File: rtl/pong_game_ctrl.sv
// Pong sequencing controller: game FSM, scoring, serve direction and ball-speed escalation.
// Every output is a flop; pulses appear one cycle after the event that causes them.
module pong_game_ctrl
  import pong_pkg::*;
#(
  parameter int unsigned TICK_DIV       = 500_000,
  parameter int unsigned SERVE_TICKS    = 60,
  parameter int unsigned WIN_SCORE      = 7,
  parameter int unsigned HITS_PER_LEVEL = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               paddle_collision,
  input  logic               wall_collision,
  input  logic               miss_p1,
  input  logic               miss_p2,
  output logic               frame_tick,
  output logic               move_en,
  output logic               ball_reset,
  output logic               serve_dir,
  output logic               ball_x_flip,
  output logic               ball_y_flip,
  output logic [SPEED_W-1:0] speed_level,
  output logic [SCORE_W-1:0] p1_score,
  output logic [SCORE_W-1:0] p2_score,
  output logic [2:0]         game_state,
  output logic               game_over
);

  localparam int unsigned SrvW = (SERVE_TICKS > 1) ? $clog2(SERVE_TICKS) : 1;
  localparam int unsigned HitW = (HITS_PER_LEVEL > 1) ? $clog2(HITS_PER_LEVEL) : 1;
  localparam logic [SrvW-1:0]    ServeLast = SrvW'(SERVE_TICKS - 1);
  localparam logic [HitW-1:0]    HitLast   = HitW'(HITS_PER_LEVEL - 1);
  localparam logic [SCORE_W-1:0] WinScore  = SCORE_W'(WIN_SCORE);

  logic tick_next;

  frame_tick_gen #(
    .TICK_DIV(TICK_DIV)
  ) u_tick (
    .clk_i      (clk),
    .rst_ni     (reset),
    .tick_next_o(tick_next),
    .tick_o     (frame_tick)
  );

  game_state_t        state_q, state_d;
  logic [SrvW-1:0]    serve_cnt_q, serve_cnt_d;
  logic [HitW-1:0]    hit_q, hit_d;
  logic [SPEED_W-1:0] speed_q, speed_d;
  logic [SCORE_W-1:0] p1_q, p1_d, p2_q, p2_d;
  logic               dir_q, dir_d;
  logic               start_q;
  logic               br_q, br_d;
  logic               xf_q, xf_d, yf_q, yf_d;
  logic               move_en_q, move_en_d;
  logic               over_q, over_d;
  logic               start_rise;

  always_comb begin
    state_d     = state_q;
    serve_cnt_d = serve_cnt_q;
    hit_d       = hit_q;
    speed_d     = speed_q;
    p1_d        = p1_q;
    p2_d        = p2_q;
    dir_d       = dir_q;
    br_d        = 1'b0;
    xf_d        = 1'b0;
    yf_d        = 1'b0;
    start_rise  = start & ~start_q;

    unique case (state_q)
      IDLE: begin
        if (start_rise) begin
          state_d = SERVE;
          br_d    = 1'b1;
          dir_d   = 1'b0;
        end
      end
      SERVE: begin
        if (frame_tick) begin
          if (serve_cnt_q == ServeLast) begin
            state_d     = PLAY;
            serve_cnt_d = '0;
          end else begin
            serve_cnt_d = serve_cnt_q + SrvW'(1);
          end
        end
      end
      PLAY: begin
        // A miss ends the rally, so any collision in the same cycle is dropped.
        if (miss_p1 || miss_p2) begin
          state_d = POINT;
          if (miss_p1 && !miss_p2) begin
            p2_d  = sat_inc(p2_q, WinScore);
            dir_d = 1'b0;
          end else if (miss_p2 && !miss_p1) begin
            p1_d  = sat_inc(p1_q, WinScore);
            dir_d = 1'b1;
          end
        end else begin
          yf_d = paddle_collision;
          xf_d = wall_collision;
          if (paddle_collision) begin
            if (hit_q == HitLast) begin
              hit_d = '0;
              if (speed_q != '1) speed_d = speed_q + SPEED_W'(1);
            end else begin
              hit_d = hit_q + HitW'(1);
            end
          end
        end
      end
      POINT: begin
        if (p1_q == WinScore || p2_q == WinScore) begin
          state_d = OVER;
        end else begin
          state_d = SERVE;
          br_d    = 1'b1;
        end
      end
      OVER: begin
        if (start_rise) begin
          state_d = SERVE;
          p1_d    = '0;
          p2_d    = '0;
          br_d    = 1'b1;
          dir_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    // Every recentre starts a fresh rally at base speed.
    if (br_d) begin
      hit_d       = '0;
      speed_d     = '0;
      serve_cnt_d = '0;
    end

    move_en_d = tick_next && (state_d == PLAY);
    over_d    = (state_d == OVER);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      serve_cnt_q <= '0;
      hit_q       <= '0;
      speed_q     <= '0;
      p1_q        <= '0;
      p2_q        <= '0;
      dir_q       <= 1'b0;
      start_q     <= 1'b0;
      br_q        <= 1'b0;
      xf_q        <= 1'b0;
      yf_q        <= 1'b0;
      move_en_q   <= 1'b0;
      over_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      serve_cnt_q <= serve_cnt_d;
      hit_q       <= hit_d;
      speed_q     <= speed_d;
      p1_q        <= p1_d;
      p2_q        <= p2_d;
      dir_q       <= dir_d;
      start_q     <= start;
      br_q        <= br_d;
      xf_q        <= xf_d;
      yf_q        <= yf_d;
      move_en_q   <= move_en_d;
      over_q      <= over_d;
    end
  end

  assign move_en     = move_en_q;
  assign ball_reset  = br_q;
  assign serve_dir   = dir_q;
  assign ball_x_flip = xf_q;
  assign ball_y_flip = yf_q;
  assign speed_level = speed_q;
  assign p1_score    = p1_q;
  assign p2_score    = p2_q;
  assign game_state  = state_q;
  assign game_over   = over_q;

endmodule

// File: doc/pong_game_ctrl.md
# pong_game_ctrl

Sequencing controller for the Pong playfield datapath: it owns the frame-rate tick, the game state machine (idle, serve, play, point, game over), scoring and ball-speed escalation. It sits between the player inputs and the paddle/ball movement datapath. It consumes collision and miss events from the datapath and issues move enables, direction-flip pulses and ball-recentre commands back to it. All outputs are registered.

## Interface
- TICK_DIV, 500_000: clk cycles per frame tick.
- SERVE_TICKS, 60: frame ticks spent in SERVE before play resumes.
- WIN_SCORE, 7: score that ends the game.
- HITS_PER_LEVEL, 4: paddle hits per speed increment.

- clk  in  1  single system clock.
- reset  in  1  asynchronous, active-low; clears all state.
- start  in  1  start/restart button, already synchronised to clk; acted on at rising edge only.
- paddle_collision  in  1  ball touched a paddle this cycle.
- wall_collision  in  1  ball touched a side wall this cycle.
- miss_p1  in  1  ball passed the p1 (bottom) paddle line.
- miss_p2  in  1  ball passed the p2 (top) paddle line.
- frame_tick  out  1  one-cycle pulse every TICK_DIV cycles, free-running.
- move_en  out  1  frame_tick gated by state == PLAY.
- ball_reset  out  1  one-cycle pulse: recentre ball, load serve_dir.
- serve_dir  out  1  0 = serve toward p1, 1 = serve toward p2; held stable.
- ball_x_flip  out  1  one-cycle pulse: invert ball x direction.
- ball_y_flip  out  1  one-cycle pulse: invert ball y direction.
- speed_level  out  2  ball speed, 0..3, saturating.
- p1_score  out  4  points won by p1.
- p2_score  out  4  points won by p2.
- game_state  out  3  current state encoding.
- game_over  out  1  high while in OVER.

## Operation
- Reset values: every output is 0, state is IDLE, and all internal counters are 0.
- IDLE: scores are held at 0. A start rising edge goes to SERVE, pulses ball_reset and sets serve_dir = 0.
- SERVE: count frame_ticks. When the count reaches SERVE_TICKS, go to PLAY and clear the count. Collision and miss inputs are ignored.
- PLAY: move_en follows frame_tick. Events are evaluated every cycle with this priority:
  - Miss beats collision.
  - miss_p1 alone: p2 scores, and the next serve goes toward p1 (serve_dir = 0).
  - miss_p2 alone: p1 scores, and serve_dir = 1.
  - Both misses in the same cycle: no score change, serve_dir unchanged.
  - Any miss: go to POINT.
  - Otherwise, paddle_collision pulses ball_y_flip and wall_collision pulses ball_x_flip. Both may pulse in the same cycle.
- Speed: each paddle_collision in PLAY increments a hit counter (0..HITS_PER_LEVEL-1). When it wraps, speed_level increments, saturating at 3. Both the hit counter and speed_level clear on every ball_reset.
- POINT: single cycle. If either score equals WIN_SCORE, go to OVER. Otherwise go to SERVE and pulse ball_reset.
- OVER: game_over = 1 and scores are frozen. A start rising edge clears the scores, pulses ball_reset, sets serve_dir = 0 and goes to SERVE.
- start edges seen in SERVE, PLAY or POINT are ignored.
- Scores saturate at WIN_SCORE; no wrap-around.

## Timing
- The tick counter runs 0..TICK_DIV-1. frame_tick is asserted in the cycle after the counter equals TICK_DIV-1.
- The tick counter runs in every state and is reset only by reset.
- Event to pulse latency is 1 cycle, for both input-to-flip and input-to-score.
- Score update to state change:
  - miss at cycle N gives score updated and state = POINT at N+1.
  - SERVE (or OVER) plus ball_reset then appears at N+2.
- A start edge at cycle N gives state = SERVE and ball_reset at N+1.
- reset asserted mid-game forces IDLE asynchronously and clears all outputs. Operation restarts on the first clk edge after deassertion.
- A ball_reset pulse is never coincident with a flip pulse.

## Structure
- Shared package pong_pkg:
  - game_state_t enum: IDLE=0, SERVE=1, PLAY=2, POINT=3, OVER=4.
  - Score width constant SCORE_W = 4.
  - Speed width SPEED_W = 2.
- Sub-module frame_tick_gen (parameter TICK_DIV), so the tick generator can be reused by the display and paddle logic.
- The FSM, scoring and speed logic stay in pong_game_ctrl.

## Test plan
- Reset and tick: hold reset low for 5 cycles, then release with TICK_DIV=10.
  - All outputs read 0.
  - frame_tick pulses every 10 cycles; move_en stays 0.
- Serve flow: start pulse, with SERVE_TICKS=3 and TICK_DIV=10.
  - ball_reset appears 1 cycle after the start edge.
  - PLAY is entered after 3 frame_ticks; move_en matches frame_tick.
- Collisions: in PLAY, assert paddle_collision and wall_collision together.
  - ball_y_flip and ball_x_flip both pulse 1 cycle later.
  - 4 paddle hits give speed_level = 1; 16 hits give speed_level = 3, saturated.
- Scoring priority: in PLAY, assert miss_p1 with paddle_collision.
  - p2_score goes 0→1, with no ball_y_flip.
  - POINT then SERVE, with ball_reset, serve_dir = 0 and speed_level cleared to 0.
- Simultaneous misses: assert miss_p1 and miss_p2 together.
  - Both scores are unchanged and serve_dir is unchanged.
  - The sequence still passes through POINT to SERVE.
- Game over and restart: with WIN_SCORE=2, p1 wins two points.
  - game_over = 1 and p1_score = 2; further misses are ignored.
  - A start edge clears the scores and enters SERVE.
  - Asserting reset mid-PLAY returns to IDLE immediately.
